// File: rtl/router_1x3.sv
// 1-input, 3-output byte-serial packet router: input FSM with parity check,
// and per-port FIFO + unread-timeout lanes.
module router_port #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       we,
  input  logic       re,
  input  logic [8:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       soft_reset
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] idle_cnt;
  logic          do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign do_wr = we & ~full;
  assign do_rd = re & ~empty;
  // Fires on the edge where the port would have sat unread for TIMEOUT cycles.
  assign soft_reset = ~empty & ~re & (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock)
    if (do_wr) mem[wr_ptr] <= din;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    dout <= '0;
    else if (do_rd) dout <= mem[rd_ptr][7:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                        idle_cnt <= '0;
    else if (empty | re | soft_reset)   idle_cnt <= '0;
    else                                idle_cnt <= idle_cnt + TW'(1);
  end
endmodule

module router_1x3 #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic [7:0] data_in,
  input  logic       pkt_valid,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic       error,
  output logic       busy
);
  localparam int NUM_PORTS = 3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'b000,
    LOAD_FIRST_DATA    = 3'b001,
    WAIT_TILL_EMPTY    = 3'b010,
    LOAD_DATA          = 3'b011,
    LOAD_PARITY        = 3'b100,
    FIFO_FULL_STATE    = 3'b101,
    CHECK_PARITY_ERROR = 3'b110,
    LOAD_AFTER_FULL    = 3'b111
  } state_t;

  state_t state, next_state;

  logic [NUM_PORTS-1:0]      empty, full, soft_reset, re;
  logic [NUM_PORTS-1:0][7:0] dout;
  logic [3:0] empty4, full4, srst4;
  logic [1:0] addr;
  logic [7:0] hdr, parity_in, int_parity, held;
  logic       held_vld, par_done;
  logic       wr_en, hdr_ok, fifo_empty, fifo_full, fifo_srst;
  logic [8:0] wr_data;

  assign re = {read_enb_2, read_enb_1, read_enb_0};
  // Padded so a 2-bit address indexes safely; address 3 never reaches a FIFO.
  assign empty4     = {1'b1, empty};
  assign full4      = {1'b0, full};
  assign srst4      = {1'b0, soft_reset};
  assign fifo_empty = empty4[addr];
  assign fifo_full  = full4[addr];
  assign fifo_srst  = srst4[addr];
  assign hdr_ok     = pkt_valid & (data_in[1:0] != 2'b11);

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    wr_en      = 1'b0;
    wr_data    = {1'b0, data_in};
    case (state)
      DECODE_ADDRESS: begin
        busy = 1'b0;
        if (hdr_ok)
          next_state = empty4[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: begin
        wr_en      = 1'b1;
        wr_data    = {1'b1, hdr};
        next_state = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: if (fifo_empty) next_state = LOAD_FIRST_DATA;
      LOAD_DATA: begin
        busy  = 1'b0;
        wr_en = pkt_valid;
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        wr_en   = held_vld;
        wr_data = {1'b0, held};
        // Without a held data byte the parity was already captured in LOAD_DATA.
        if (par_done)                    next_state = DECODE_ADDRESS;
        else if (!held_vld || !pkt_valid) next_state = LOAD_PARITY;
        else                             next_state = LOAD_DATA;
      end
      LOAD_PARITY: begin
        wr_en      = 1'b1;
        wr_data    = {1'b0, parity_in};
        next_state = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default: next_state = DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && fifo_srst) next_state = DECODE_ADDRESS;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= DECODE_ADDRESS;
      addr       <= '0;
      hdr        <= '0;
      parity_in  <= '0;
      int_parity <= '0;
      held       <= '0;
      held_vld   <= 1'b0;
      par_done   <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        DECODE_ADDRESS: if (hdr_ok) begin
          addr       <= data_in[1:0];
          hdr        <= data_in;
          int_parity <= data_in;
          error      <= 1'b0;
          held_vld   <= 1'b0;
          par_done   <= 1'b0;
        end
        LOAD_DATA: begin
          if (pkt_valid) int_parity <= int_parity ^ data_in;
          else           parity_in  <= data_in;
          held     <= data_in;
          held_vld <= fifo_full & pkt_valid;
        end
        LOAD_AFTER_FULL: if (held_vld && !pkt_valid) parity_in <= data_in;
        CHECK_PARITY_ERROR: begin
          error <= (int_parity != parity_in);
          if (fifo_full) begin
            par_done <= 1'b1;
            held_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    router_port #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) u_port (
      .clock      (clock),
      .resetn     (resetn),
      .we         (wr_en && (addr == 2'(p))),
      .re         (re[p]),
      .din        (wr_data),
      .dout       (dout[p]),
      .empty      (empty[p]),
      .full       (full[p]),
      .soft_reset (soft_reset[p])
    );
  end

  assign data_out_0  = dout[0];
  assign data_out_1  = dout[1];
  assign data_out_2  = dout[2];
  assign valid_out_0 = ~empty[0];
  assign valid_out_1 = ~empty[1];
  assign valid_out_2 = ~empty[2];
endmodule

// File: tb/tb_router_1x3.sv
// Scoreboard bench for router_1x3: packet bytes are queued per port as they are
// driven and compared against data_out_x as each read pops them.
module tb_router_1x3;
  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] rd;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic       error, busy;
  logic [2:0] vo;

  int errors = 0;
  int checks = 0;
  int pops [3];
  logic [7:0] sb [3][$];
  logic [2:0] pend;

  always #5 clock = ~clock;

  router_1x3 #(.FIFO_DEPTH(16), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn),
    .read_enb_0(rd[0]), .read_enb_1(rd[1]), .read_enb_2(rd[2]),
    .data_in(data_in), .pkt_valid(pkt_valid),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .error(error), .busy(busy)
  );

  assign vo = {valid_out_2, valid_out_1, valid_out_0};

  always @(posedge clock or negedge resetn)
    if (!resetn) pend <= '0;
    else         pend <= rd & vo;

  always @(negedge clock) begin : monitor
    logic [7:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        case (i)
          0:       got = data_out_0;
          1:       got = data_out_1;
          default: got = data_out_2;
        endcase
        pops[i]++;
        checks++;
        if (sb[i].size() == 0) begin
          errors++;
          $display("FAIL pop_port%0d unexpected byte got=%h expected none", i, got);
        end else begin
          exp = sb[i].pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL pop_port%0d got=%h expected=%h", i, got, exp);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic flush();
    for (int i = 0; i < 3; i++) sb[i].delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0; rd = '0; pkt_valid = 1'b0; data_in = '0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    flush();
  endtask

  task automatic send_pkt(input logic [1:0] addr, input int len, input logic bad,
                          output int stalls);
    logic [7:0] b [$];
    logic [7:0] par, x;
    int g;
    par = {6'(len), addr};
    b.push_back(par);
    for (int k = 0; k < len; k++) begin
      x = 8'($urandom);
      b.push_back(x);
      par ^= x;
    end
    b.push_back(bad ? ~par : par);
    if (addr != 2'd3) foreach (b[k]) sb[addr].push_back(b[k]);
    stalls = 0;
    for (int i = 0; i < b.size(); i++) begin
      pkt_valid = (i < b.size() - 1);
      data_in   = b[i];
      g = 0;
      while (busy && g < 100) begin @(negedge clock); stalls++; g++; end
      if (g >= 100) begin
        errors++; checks++;
        $display("FAIL send_busy_stuck byte=%0d busy=%b expected 0", i, busy);
        i = b.size();
      end else begin
        @(negedge clock);
      end
    end
    pkt_valid = 1'b0;
    data_in   = '0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output logic hit);
    int c;
    c = 0;
    while (dut.state !== s && c < limit) begin @(negedge clock); c++; end
    hit = (dut.state === s);
  endtask

  task automatic drain(input int p, input int limit);
    int c;
    c = 0;
    rd[p] = 1'b1;
    while ((vo[p] || dut.state !== 3'b000) && c < limit) begin @(negedge clock); c++; end
    rd[p] = 1'b0;
    @(negedge clock);
    checks++;
    if (c >= limit) begin
      errors++;
      $display("FAIL drain_port%0d timeout valid_out=%b state=%0d expected 0/0", p, vo[p], dut.state);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (vo !== 3'b000) begin errors++; $display("FAIL reset_valid got=%b expected=000", vo); end
    checks++; if ({data_out_2, data_out_1, data_out_0} !== 24'h0) begin
      errors++; $display("FAIL reset_data got=%h expected=0", {data_out_2, data_out_1, data_out_0}); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b expected=0", error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", busy); end
    checks++; if (dut.state !== 3'b000) begin errors++; $display("FAIL reset_state got=%0d expected=0", dut.state); end
  endtask

  task automatic test_basic();
    int st, p0;
    p0 = pops[1];
    send_pkt(2'd1, 8, 1'b0, st);
    checks++; if (st != 1) begin errors++; $display("FAIL basic_stalls got=%0d expected=1", st); end
    repeat (2) @(negedge clock);
    checks++; if (dut.state !== 3'b000) begin errors++; $display("FAIL basic_state got=%0d expected=0", dut.state); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got=%b expected=0", error); end
    checks++; if (valid_out_1 !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b expected=1", valid_out_1); end
    drain(1, 40);
    checks++; if (pops[1] - p0 != 10) begin errors++; $display("FAIL basic_pops got=%0d expected=10", pops[1] - p0); end
    checks++; if (valid_out_1 !== 1'b0) begin errors++; $display("FAIL basic_valid_end got=%b expected=0", valid_out_1); end
  endtask

  task automatic test_full();
    int st, p0;
    logic hit;
    p0 = pops[1];
    fork
      send_pkt(2'd1, 16, 1'b0, st);
      begin
        wait_state(3'b101, 40, hit);
        checks++; if (!hit) begin errors++; $display("FAIL full_reach_ffs state=%0d expected=5", dut.state); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%b expected=1", busy); end
        checks++; if (dut.full[1] !== 1'b1) begin errors++; $display("FAIL full_flag got=%b expected=1", dut.full[1]); end
        rd[1] = 1'b1;
        wait_state(3'b111, 10, hit);
        checks++; if (!hit) begin errors++; $display("FAIL full_reach_laf state=%0d expected=7", dut.state); end
      end
    join
    drain(1, 60);
    checks++; if (pops[1] - p0 != 18) begin errors++; $display("FAIL full_pops got=%0d expected=18", pops[1] - p0); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL full_error got=%b expected=0", error); end
  endtask

  task automatic test_parity_err();
    int st, p0;
    p0 = pops[0];
    send_pkt(2'd0, 14, 1'b1, st);
    repeat (2) @(negedge clock);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL perr_error got=%b expected=1", error); end
    checks++; if (dut.state !== 3'b101) begin errors++; $display("FAIL perr_state got=%0d expected=5", dut.state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL perr_busy got=%b expected=1", busy); end
    drain(0, 40);
    checks++; if (pops[0] - p0 != 16) begin errors++; $display("FAIL perr_pops got=%0d expected=16", pops[0] - p0); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b expected=1", error); end
    resetn = 1'b0;
    #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL perr_reset got=%b expected=0", error); end
    do_reset();
  endtask

  task automatic test_timeout();
    int st, hi, p0;
    logic seen;
    hi = 0; seen = 1'b0; p0 = pops[2];
    fork
      send_pkt(2'd2, 5, 1'b0, st);
      for (int c = 0; c < 100 && !(seen && !valid_out_2); c++) begin
        @(negedge clock);
        if (valid_out_2) begin hi++; seen = 1'b1; end
      end
    join
    checks++; if (hi != 30) begin errors++; $display("FAIL timeout_cycles got=%0d expected=30", hi); end
    checks++; if (valid_out_2 !== 1'b0) begin errors++; $display("FAIL timeout_valid got=%b expected=0", valid_out_2); end
    checks++; if (dut.state !== 3'b000) begin errors++; $display("FAIL timeout_state got=%0d expected=0", dut.state); end
    checks++; if (pops[2] != p0) begin errors++; $display("FAIL timeout_pops got=%0d expected=%0d", pops[2], p0); end
    sb[2].delete();
  endtask

  task automatic test_wait();
    int st, st2, p0;
    logic hit;
    p0 = pops[1];
    send_pkt(2'd1, 2, 1'b0, st);
    fork
      send_pkt(2'd1, 3, 1'b0, st2);
      begin
        repeat (3) @(negedge clock);
        checks++; if (dut.state !== 3'b010) begin errors++; $display("FAIL wait_state got=%0d expected=2", dut.state); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got=%b expected=1", busy); end
        rd[1] = 1'b1;
        wait_state(3'b001, 20, hit);
        checks++; if (!hit) begin errors++; $display("FAIL wait_to_lfd state=%0d expected=1", dut.state); end
      end
    join
    drain(1, 40);
    checks++; if (pops[1] - p0 != 9) begin errors++; $display("FAIL wait_pops got=%0d expected=9", pops[1] - p0); end
  endtask

  task automatic test_addr3();
    data_in = {6'd4, 2'b11}; pkt_valid = 1'b1;
    @(negedge clock);
    pkt_valid = 1'b0; data_in = '0;
    checks++; if (dut.state !== 3'b000) begin errors++; $display("FAIL addr3_state got=%0d expected=0", dut.state); end
    repeat (3) @(negedge clock);
    checks++; if (vo !== 3'b000) begin errors++; $display("FAIL addr3_valid got=%b expected=000", vo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addr3_busy got=%b expected=0", busy); end
  endtask

  task automatic test_reset_mid(input logic [2:0] target, input logic prefill);
    logic [7:0] b [4];
    logic bz, hit;
    int idx, st;
    if (prefill) send_pkt(2'd1, 1, 1'b0, st);
    b[0] = {6'd2, 2'd1}; b[1] = 8'h5a; b[2] = 8'hc3; b[3] = b[0] ^ b[1] ^ b[2];
    idx = 0; hit = 1'b0;
    pkt_valid = 1'b1; data_in = b[0];
    for (int c = 0; c < 20 && !hit; c++) begin
      bz = busy;
      @(negedge clock);
      if (dut.state === target) hit = 1'b1;
      else begin
        if (!bz && idx < 4) idx++;
        pkt_valid = (idx < 3);
        data_in   = (idx < 4) ? b[idx] : 8'h00;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid%0d_reach state=%0d expected=%0d", target, dut.state, target); end
    resetn = 1'b0;
    #1;
    checks++; if (dut.state !== 3'b000) begin errors++; $display("FAIL rmid%0d_state got=%0d expected=0", target, dut.state); end
    checks++; if (vo !== 3'b000) begin errors++; $display("FAIL rmid%0d_valid got=%b expected=000", target, vo); end
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid%0d_flags error=%b busy=%b expected 0/0", target, error, busy); end
    do_reset();
  endtask

  initial begin
    pops[0] = 0; pops[1] = 0; pops[2] = 0;
    test_reset();
    test_basic();
    test_full();
    test_parity_err();
    test_timeout();
    test_wait();
    test_addr3();
    test_reset_mid(3'b001, 1'b0);
    test_reset_mid(3'b010, 1'b1);
    test_reset_mid(3'b011, 1'b0);
    test_reset_mid(3'b100, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
